sfu_out_pack: RTL and testbench

Output packing stage between the SFU compute core and the SFU AXI-stream output port consumed by the write DMA. It buffers NUM_CH x 16-bit result vectors from the SFU core in a small FIFO and emits them as AXI-stream beats. It counts beats against the per-layer step count (`params_step_num`), asserts `tlast` on the final beat of a step and pulses `done` when the step has fully drained. It also decouples core back-pressure from DMA back-pressure.

---
 rtl/sfu_out_pack.sv | 167 ++++++++++++++++
 tb/tb_sfu_out_pack.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfu_out_pack.sv
// sfu_out_pack: buffers SFU core result vectors in a small FIFO and emits them
// as AXI-stream beats, counting beats against the step length, flagging the
// final beat with tlast and pulsing done once the whole step has drained.
module sfu_out_pack #(
    parameter int NUM_CH     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             params_step_num,
    input  logic                   s_sfu_valid,
    output logic                   s_sfu_ready,
    input  logic [NUM_CH*16-1:0]   s_sfu_data,
    output logic                   m_sfu_axis_tvalid,
    input  logic                   m_sfu_axis_tready,
    output logic [NUM_CH*16-1:0]   m_sfu_axis_tdata,
    output logic                   m_sfu_axis_tlast,
    output logic                   busy,
    output logic                   done,
    output logic                   err_extra
);

    localparam int W  = NUM_CH * 16;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [7:0]     total;
    logic [8:0]     total_ext;
    logic [8:0]     in_cnt;
    logic [8:0]     out_cnt;

    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [W-1:0]   mem [FIFO_DEPTH];

    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           start_ok;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty = (wr_ptr == rd_ptr);

    assign total_ext = {1'b0, total};
    assign start_ok  = start && (state == IDLE);

    // Core side only accepts in RUN, and only while beats remain and there is room;
    // the full check ignores a concurrent pop so tready never reaches s_sfu_ready.
    assign s_sfu_ready = (state == RUN) && !fifo_full && (in_cnt != total_ext);
    assign push        = s_sfu_valid && s_sfu_ready;

    // Output side is live in every state; tdata is forced to zero when nothing is held.
    assign m_sfu_axis_tvalid = !fifo_empty;
    assign m_sfu_axis_tdata  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign m_sfu_axis_tlast  = m_sfu_axis_tvalid && (out_cnt == total_ext - 9'd1);
    assign pop               = m_sfu_axis_tvalid && m_sfu_axis_tready;

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (params_step_num == 8'd0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (push && (in_cnt + 9'd1 == total_ext)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (out_cnt + 9'd1 == total_ext)) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Step length and beat counters; start re-arms them, handshakes advance them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total   <= 8'd0;
            in_cnt  <= 9'd0;
            out_cnt <= 9'd0;
        end else begin
            if (start_ok) begin
                total   <= params_step_num;
                in_cnt  <= 9'd0;
                out_cnt <= 9'd0;
            end else begin
                if (push) begin
                    in_cnt <= in_cnt + 9'd1;
                end
                if (pop) begin
                    out_cnt <= out_cnt + 9'd1;
                end
            end
        end
    end

    // FIFO pointers; reset flushes any buffered beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage write.
    // NOTE: the data array has no reset; validity is tracked by the pointers and
    // the output mux zeroes tdata while empty, so resetting it would only add muxes.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_sfu_data;
        end
    end

    // Sticky flag for core results offered while no step is accepting them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_extra <= 1'b0;
        end else if (s_sfu_valid && ((state == IDLE) || (state == FIN))) begin
            err_extra <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sfu_out_pack.sv
// Self-checking bench for sfu_out_pack: expected beats are queued when a step is
// armed and popped against every output handshake seen by a negedge monitor.
module tb_sfu_out_pack;

    localparam int NUM_CH     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int W          = NUM_CH * 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic [7:0]     params_step_num;
    logic           s_sfu_valid;
    logic           s_sfu_ready;
    logic [W-1:0]   s_sfu_data;
    logic           tvalid;
    logic           tready;
    logic [W-1:0]   tdata;
    logic           tlast;
    logic           busy;
    logic           done;
    logic           err_extra;

    sfu_out_pack #(
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .params_step_num   (params_step_num),
        .s_sfu_valid       (s_sfu_valid),
        .s_sfu_ready       (s_sfu_ready),
        .s_sfu_data        (s_sfu_data),
        .m_sfu_axis_tvalid (tvalid),
        .m_sfu_axis_tready (tready),
        .m_sfu_axis_tdata  (tdata),
        .m_sfu_axis_tlast  (tlast),
        .busy              (busy),
        .done              (done),
        .err_extra         (err_extra)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cycle = 0;
    int           in_hs, out_hs, tlast_cnt, tvalid_cycles, last_hs_cycle;
    logic         prev_valid, prev_ready, prev_last;
    logic [W-1:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [W-1:0] beat(input int k, input int tag);
        logic [W-1:0] b;
        for (int i = 0; i < NUM_CH; i++) begin
            b[16*i +: 16] = 16'(k) ^ 16'(i << 8) ^ 16'(tag << 12);
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: AXI hold rule, scoreboard pops, handshake bookkeeping.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                check("hold_valid", tvalid, 1);
                check("hold_data", tdata, prev_data);
                check("hold_last", tlast, prev_last);
            end
            if (s_sfu_valid && s_sfu_ready) in_hs++;
            if (tvalid) tvalid_cycles++;
            if (tvalid && tready) begin
                exp_t e;
                out_hs++;
                last_hs_cycle = cycle;
                if (tlast) tlast_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", tdata, e.data);
                    check("beat_last", tlast, e.last);
                end
            end
            prev_valid = tvalid;
            prev_ready = tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    // Arms a step of n beats and drives it to completion with the given
    // valid/ready probabilities, an initial tready stall and optional misuse.
    task automatic run_step(input int n, input int tag, input int p_valid, input int p_ready,
                            input int stall, input bit restart, input bit overdrive);
        int  k;
        int  cyc;
        int  done_cyc;
        bit  hs;
        bit  seen_done;
        for (int i = 0; i < n; i++) exp_q.push_back('{beat(i, tag), (i == n - 1)});
        in_hs = 0; out_hs = 0; tlast_cnt = 0; tvalid_cycles = 0;
        params_step_num = 8'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        params_step_num = 8'($urandom);
        check("busy_after_start", busy, 1);
        k = 0; cyc = 0; seen_done = 0; done_cyc = -1;
        while (!seen_done && cyc < 4000) begin
            if (k < n) s_sfu_valid = ($urandom_range(99) < p_valid);
            else       s_sfu_valid = overdrive && busy && !done;
            s_sfu_data = beat(k, tag);
            tready = (cyc >= stall) && ($urandom_range(99) < p_ready);
            start = restart && (cyc == 2);
            if (restart) params_step_num = 8'(n + 5);
            if (stall > 0 && cyc == stall) check("stall_pushes", in_hs, FIFO_DEPTH);
            @(negedge clk);
            hs = s_sfu_valid && s_sfu_ready;
            if (done) begin
                seen_done = 1;
                done_cyc  = cyc;
                if (n > 0) check("done_latency", cycle, last_hs_cycle + 1);
            end
            tick();
            if (hs) k++;
            cyc++;
        end
        s_sfu_valid = 1'b0;
        tready = 1'b0;
        start = 1'b0;
        check("done_seen", seen_done, 1);
        check("queue_empty", exp_q.size(), 0);
        check("in_count", in_hs, n);
        check("out_count", out_hs, n);
        check("tlast_count", tlast_cnt, (n > 0) ? 1 : 0);
        if (n == 0) begin
            check("zero_done_cycle", done_cyc, 0);
            check("zero_no_tvalid", tvalid_cycles, 0);
        end
        check("done_pulse", done, 0);
        check("busy_cleared", busy, 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        int  guard;
        bit  hs;
        rst = 1'b1;
        start = 1'b0;
        params_step_num = 8'd0;
        s_sfu_valid = 1'b0;
        s_sfu_data = '0;
        tready = 1'b0;
        #1;
        check("rst_ready", s_sfu_ready, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_extra, 0);
        check("rst_tdata", tdata, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Basic streaming, back-pressure, random handshakes, zero-length step.
        run_step(4, 0, 100, 100, 0, 1'b0, 1'b0);
        run_step(8, 1, 100, 100, 10, 1'b0, 1'b0);
        run_step(255, 2, 60, 60, 0, 1'b0, 1'b1);
        run_step(0, 3, 100, 100, 0, 1'b0, 1'b0);
        check("err_clean", err_extra, 0);

        // Misuse: valid in IDLE, then a start pulse in the middle of RUN.
        s_sfu_valid = 1'b1;
        tick();
        s_sfu_valid = 1'b0;
        check("err_set", err_extra, 1);
        run_step(5, 4, 100, 100, 0, 1'b1, 1'b0);
        check("err_sticky", err_extra, 1);

        // Reset in the middle of a step with three beats buffered.
        params_step_num = 8'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        tready = 1'b0;
        k = 0; guard = 0;
        while (k < 3 && guard < 50) begin
            s_sfu_valid = 1'b1;
            s_sfu_data = beat(k, 5);
            @(negedge clk);
            hs = s_sfu_valid && s_sfu_ready;
            tick();
            if (hs) k++;
            guard++;
        end
        s_sfu_valid = 1'b0;
        check("buffered_three", k, 3);
        check("buffered_tvalid", tvalid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tvalid", tvalid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_err", err_extra, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        run_step(2, 6, 100, 100, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
